leds_pwm: RTL and testbench

Parametrised Avalon-MM LED peripheral and successor to the single 8-bit LED register. Each of CHANNELS outputs gets an on/off bit, a PWM duty register and a blink-mask bit. Global prescaler and blink-divider registers set the timing. Sits on the Nios/Avalon bus as slave s1 and drives the board LED pins through user_dataout_0.

---
 rtl/leds_pwm_if.sv | 26 ++
 rtl/leds_pwm.sv | 195 +++++++++++++++++++
 tb/tb_leds_pwm.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leds_pwm_if.sv
// Avalon-MM slave port bundle (s1) for the leds_pwm LED peripheral.
// The master modport is the bus side (Nios/Avalon fabric); the slave modport
// is the peripheral side.
interface leds_pwm_if;
    logic [4:0]  avs_s1_address;
    logic        avs_s1_read;
    logic [15:0] avs_s1_readdata;
    logic        avs_s1_write;
    logic [15:0] avs_s1_writedata;

    modport master (
        output avs_s1_address,
        output avs_s1_read,
        output avs_s1_write,
        output avs_s1_writedata,
        input  avs_s1_readdata
    );

    modport slave (
        input  avs_s1_address,
        input  avs_s1_read,
        input  avs_s1_write,
        input  avs_s1_writedata,
        output avs_s1_readdata
    );
endinterface

// File: rtl/leds_pwm.sv
// leds_pwm: parametrised Avalon-MM LED peripheral with per-channel on/off,
// PWM duty and blink mask, plus global prescaler and blink divider.
// Optional feature macro: LEDS_FADE_EN -- when defined, each channel's
// effective duty steps one count per PWM period toward its DUTY register.
// Register map (word address): 0x00 ON, 0x01 BLINK_MASK, 0x02 PRESCALE,
// 0x03 BLINK_DIV, 0x04 STATUS (bit0 phase, bit1 fading, [DUTY_W+3:4] pwm_cnt),
// 0x10+i DUTY[i].
module leds_pwm #(
    parameter int CHANNELS   = 8,
    parameter int DUTY_W     = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                csi_clk,
    input  logic                csi_reset,
    leds_pwm_if.slave           s1,
    output logic [CHANNELS-1:0] user_dataout_0
);

    logic [CHANNELS-1:0]   on_reg;
    logic [CHANNELS-1:0]   mask_reg;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] blink_div;
    logic [DUTY_W-1:0]     duty [CHANNELS];
    logic [DUTY_W-1:0]     eff  [CHANNELS];

    logic [PRESCALE_W-1:0] pre_cnt;
    logic [PRESCALE_W-1:0] blink_cnt;
    logic [DUTY_W-1:0]     pwm_cnt;
    logic                  phase;
    logic                  tick;
    logic                  period_end;
    logic                  fading;

    logic                  wr_on;
    logic                  wr_mask;
    logic                  wr_prescale;
    logic                  wr_blink_div;
    logic [15:0]           rd_mux;
    logic [15:0]           readdata;
    logic [CHANNELS-1:0]   lit;
    logic                  unused_writedata;

    assign wr_on        = s1.avs_s1_write && (s1.avs_s1_address == 5'h00);
    assign wr_mask      = s1.avs_s1_write && (s1.avs_s1_address == 5'h01);
    assign wr_prescale  = s1.avs_s1_write && (s1.avs_s1_address == 5'h02);
    assign wr_blink_div = s1.avs_s1_write && (s1.avs_s1_address == 5'h03);

    // Writedata is wider than most registers; upper bits are simply dropped.
    assign unused_writedata = ^s1.avs_s1_writedata;

    assign tick       = (pre_cnt == prescale);
    assign period_end = tick && (pwm_cnt == {DUTY_W{1'b1}});

    // Configuration registers; DUTY slots beyond CHANNELS do not exist.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            on_reg    <= '0;
            mask_reg  <= '0;
            prescale  <= '0;
            blink_div <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty[i] <= '0;
            end
        end else begin
            if (wr_on)        on_reg    <= s1.avs_s1_writedata[CHANNELS-1:0];
            if (wr_mask)      mask_reg  <= s1.avs_s1_writedata[CHANNELS-1:0];
            if (wr_prescale)  prescale  <= s1.avs_s1_writedata[PRESCALE_W-1:0];
            if (wr_blink_div) blink_div <= s1.avs_s1_writedata[PRESCALE_W-1:0];
            for (int i = 0; i < CHANNELS; i++) begin
                if (s1.avs_s1_write && (s1.avs_s1_address == 5'(16 + i))) begin
                    duty[i] <= s1.avs_s1_writedata[DUTY_W-1:0];
                end
            end
        end
    end

    // Prescaler and PWM counter; a PRESCALE write restarts both so the new
    // rate begins on a clean period.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (wr_prescale) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
        end
    end

    // Blink divider: counts PWM periods, toggles phase after BLINK_DIV+1 of them.
    always_ff @(posedge csi_clk) begin
        if (csi_reset || wr_blink_div) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (period_end) begin
            if (blink_cnt == blink_div) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + PRESCALE_W'(1);
            end
        end
    end

`ifdef LEDS_FADE_EN
    // Effective duty walks one step per PWM period toward the programmed duty.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                eff[i] <= '0;
            end
        end else if (period_end) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (eff[i] < duty[i]) begin
                    eff[i] <= eff[i] + DUTY_W'(1);
                end else if (eff[i] > duty[i]) begin
                    eff[i] <= eff[i] - DUTY_W'(1);
                end
            end
        end
    end

    // Fading flag: any channel still on its way to its target duty.
    always_comb begin
        fading = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (eff[i] != duty[i]) fading = 1'b1;
        end
    end
`else
    // Without fading the programmed duty drives the comparator directly.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            eff[i] = duty[i];
        end
    end

    assign fading = 1'b0;
`endif

    // Per-channel lit decision; all-ones duty is forced fully on.
    always_comb begin
        lit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lit[i] = on_reg[i]
                  && ((pwm_cnt < eff[i]) || (eff[i] == {DUTY_W{1'b1}}))
                  && !(mask_reg[i] && phase);
        end
    end

    // Registered LED drive.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            user_dataout_0 <= '0;
        end else begin
            user_dataout_0 <= lit;
        end
    end

    // Read decode; unmapped addresses and unused high bits return 0.
    always_comb begin
        rd_mux = '0;
        case (s1.avs_s1_address)
            5'h00: rd_mux[CHANNELS-1:0]   = on_reg;
            5'h01: rd_mux[CHANNELS-1:0]   = mask_reg;
            5'h02: rd_mux[PRESCALE_W-1:0] = prescale;
            5'h03: rd_mux[PRESCALE_W-1:0] = blink_div;
            5'h04: begin
                rd_mux[0]          = phase;
                rd_mux[1]          = fading;
                rd_mux[DUTY_W+3:4] = pwm_cnt;
            end
            default: ;
        endcase
        for (int i = 0; i < CHANNELS; i++) begin
            if (s1.avs_s1_address == 5'(16 + i)) rd_mux[DUTY_W-1:0] = duty[i];
        end
    end

    // Read data register: loads only on a pure read, otherwise holds.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            readdata <= '0;
        end else if (s1.avs_s1_read && !s1.avs_s1_write) begin
            readdata <= rd_mux;
        end
    end

    assign s1.avs_s1_readdata = readdata;

endmodule

// File: tb/tb_leds_pwm.sv
// Self-checking bench for leds_pwm: table-driven register vectors with a
// read-data scoreboard, plus hand-written PWM, blink and reset sequences.
// A second 4-channel instance shares the same bus stimulus.
module tb_leds_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] led8;
    logic [3:0] led4;

    always #5 clk = ~clk;

    leds_pwm_if bus ();
    leds_pwm_if bus4 ();

    assign bus4.avs_s1_address   = bus.avs_s1_address;
    assign bus4.avs_s1_read      = bus.avs_s1_read;
    assign bus4.avs_s1_write     = bus.avs_s1_write;
    assign bus4.avs_s1_writedata = bus.avs_s1_writedata;

    leds_pwm #(.CHANNELS(8), .DUTY_W(8), .PRESCALE_W(16)) u_dut (
        .csi_clk        (clk),
        .csi_reset      (rst),
        .s1             (bus.slave),
        .user_dataout_0 (led8)
    );

    leds_pwm #(.CHANNELS(4), .DUTY_W(8), .PRESCALE_W(16)) u_dut4 (
        .csi_clk        (clk),
        .csi_reset      (rst),
        .s1             (bus4.slave),
        .user_dataout_0 (led4)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] exp;
        logic [15:0] mask;
        logic        dut4;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] data;
        string       name;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop();
        sb_t e;
        logic [15:0] act;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got no entry, expected one queued");
            return;
        end
        e   = sb_q.pop_front();
        act = e.dut4 ? bus4.avs_s1_readdata : bus.avs_s1_readdata;
        check(e.name, act & e.mask, e.exp & e.mask);
    endtask

    task automatic bus_cycle(input logic rd, input logic wr, input logic [4:0] addr, input logic [15:0] wdata);
        @(negedge clk);
        bus.avs_s1_read      = rd;
        bus.avs_s1_write     = wr;
        bus.avs_s1_address   = addr;
        bus.avs_s1_writedata = wdata;
        @(negedge clk);
        bus.avs_s1_read  = 1'b0;
        bus.avs_s1_write = 1'b0;
        if (rd) sb_pop();
    endtask

    task automatic wr_reg(input logic [4:0] addr, input logic [15:0] data);
        bus_cycle(1'b0, 1'b1, addr, data);
    endtask

    task automatic rd_reg(input logic [4:0] addr, input logic [15:0] exp, input logic [15:0] mask,
                          input logic dut4, input string name);
        sb_q.push_back('{exp, mask, dut4, name});
        bus_cycle(1'b1, 1'b0, addr, 16'h0000);
    endtask

    task automatic count_lit(input int n, input int b, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (led8[b]) cnt++;
        end
    endtask

    // Leaves reset asserted after two sampled edges; caller releases it.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int   cnt;
        int   bad;
        int   run;
        int   k;
        logic v;
        logic found;

        rst                  = 1'b1;
        bus.avs_s1_read      = 1'b0;
        bus.avs_s1_write     = 1'b0;
        bus.avs_s1_address   = 5'h00;
        bus.avs_s1_writedata = 16'h0000;

        do_reset();
        check("rst_readdata", bus.avs_s1_readdata, 16'h0000);
        check("rst_leds", led8, 8'h00);
        // Release reset and read STATUS on the very first edge: counters are 0.
        rst = 1'b0;
        sb_q.push_back('{16'h0000, 16'hFFFF, 1'b0, "rst_status"});
        bus.avs_s1_read    = 1'b1;
        bus.avs_s1_address = 5'h04;
        @(negedge clk);
        bus.avs_s1_read = 1'b0;
        sb_pop();

        vecs.push_back('{1'b0, 5'h00, 16'h0000, "rst_on"});
        vecs.push_back('{1'b0, 5'h01, 16'h0000, "rst_mask"});
        vecs.push_back('{1'b0, 5'h02, 16'h0000, "rst_prescale"});
        vecs.push_back('{1'b0, 5'h03, 16'h0000, "rst_blink_div"});
        vecs.push_back('{1'b0, 5'h10, 16'h0000, "rst_duty0"});
        vecs.push_back('{1'b1, 5'h00, 16'h00A5, "wr_on"});
        vecs.push_back('{1'b0, 5'h00, 16'h00A5, "rd_on"});
        vecs.push_back('{1'b1, 5'h01, 16'hFF3C, "wr_mask"});
        vecs.push_back('{1'b0, 5'h01, 16'h003C, "rd_mask_trunc"});
        vecs.push_back('{1'b1, 5'h02, 16'h1234, "wr_prescale"});
        vecs.push_back('{1'b0, 5'h02, 16'h1234, "rd_prescale"});
        vecs.push_back('{1'b1, 5'h03, 16'hBEEF, "wr_blink_div"});
        vecs.push_back('{1'b0, 5'h03, 16'hBEEF, "rd_blink_div"});
        vecs.push_back('{1'b1, 5'h11, 16'hABCD, "wr_duty1"});
        vecs.push_back('{1'b0, 5'h11, 16'h00CD, "rd_duty1_trunc"});
        vecs.push_back('{1'b1, 5'h18, 16'h5555, "wr_unmapped18"});
        vecs.push_back('{1'b0, 5'h18, 16'h0000, "rd_unmapped18"});
        vecs.push_back('{1'b1, 5'h05, 16'h1234, "wr_unmapped05"});
        vecs.push_back('{1'b0, 5'h05, 16'h0000, "rd_unmapped05"});
        vecs.push_back('{1'b1, 5'h04, 16'hFFFF, "wr_status_ro"});
        vecs.push_back('{1'b0, 5'h00, 16'h00A5, "rd_on_after_ro"});
        vecs.push_back('{1'b0, 5'h17, 16'h0000, "rd_duty7"});

        foreach (vecs[i]) begin
            if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].data);
            else            rd_reg(vecs[i].addr, vecs[i].data, 16'hFFFF, 1'b0, vecs[i].name);
        end

        // Read and write together: write lands, readdata keeps old value.
        rd_reg(5'h01, 16'h003C, 16'hFFFF, 1'b0, "rw_pre");
        sb_q.push_back('{16'h003C, 16'hFFFF, 1'b0, "rw_hold"});
        bus_cycle(1'b1, 1'b1, 5'h00, 16'h005A);
        rd_reg(5'h00, 16'h005A, 16'hFFFF, 1'b0, "rw_on_updated");

`ifndef LEDS_FADE_EN
        // Static on, then one channel with duty 0.
        wr_reg(5'h02, 16'h0000);
        wr_reg(5'h01, 16'h0000);
        wr_reg(5'h00, 16'h00FF);
        for (int i = 0; i < 8; i++) wr_reg(5'(16 + i), 16'h00FF);
        repeat (2) @(negedge clk);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (led8 != 8'hFF) bad++;
        end
        check("static_on_bad_cycles", bad, 0);
        wr_reg(5'h13, 16'h0000);
        repeat (2) @(negedge clk);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (led8 != 8'hF7) bad++;
        end
        check("duty0_bit3_bad_cycles", bad, 0);

        // PWM duty: lit cycles over 4 full periods.
        wr_reg(5'h00, 16'h0001);
        wr_reg(5'h10, 16'd64);
        repeat (2) @(negedge clk);
        count_lit(1024, 0, cnt);
        check("pwm_duty64", cnt, 256);
        wr_reg(5'h10, 16'd0);
        repeat (2) @(negedge clk);
        count_lit(1024, 0, cnt);
        check("pwm_duty0", cnt, 0);
        wr_reg(5'h10, 16'd254);
        repeat (2) @(negedge clk);
        count_lit(1024, 0, cnt);
        check("pwm_duty254", cnt, 1016);
        wr_reg(5'h10, 16'd255);
        repeat (2) @(negedge clk);
        count_lit(1024, 0, cnt);
        check("pwm_duty255", cnt, 1024);

        // Prescale 3: one tick every 4 cycles, period 1024 cycles.
        wr_reg(5'h02, 16'd3);
        wr_reg(5'h10, 16'd64);
        repeat (2) @(negedge clk);
        count_lit(4096, 0, cnt);
        check("pwm_prescale3", cnt, 1024);
`endif

        // PRESCALE write mid-period clears pwm_cnt.
        wr_reg(5'h02, 16'h0000);
        repeat (37) @(negedge clk);
        wr_reg(5'h02, 16'd100);
        rd_reg(5'h04, 16'h0000, 16'hFFF0, 1'b0, "prescale_clr_pwm_cnt");

`ifndef LEDS_FADE_EN
        // Blink: 512 cycles on, 512 off, STATUS phase in step.
        wr_reg(5'h02, 16'h0000);
        wr_reg(5'h00, 16'h0001);
        wr_reg(5'h10, 16'h00FF);
        wr_reg(5'h01, 16'h0001);
        wr_reg(5'h03, 16'h0001);
        @(negedge clk);
        v     = led8[0];
        found = 1'b0;
        for (int t = 0; t < 1100 && !found; t++) begin
            @(negedge clk);
            if (led8[0] != v) found = 1'b1;
        end
        check("blink_edge_found", found, 1'b1);
        if (found) begin
            for (int h = 0; h < 2; h++) begin
                v   = led8[0];
                run = 1;
                k   = 0;
                while (k < 600) begin
                    @(negedge clk);
                    k++;
                    if (k == 200) begin
                        sb_q.push_back('{{15'b0, ~v}, 16'h0001, 1'b0, "blink_status_phase"});
                        bus.avs_s1_read    = 1'b1;
                        bus.avs_s1_address = 5'h04;
                    end
                    if (k == 201) begin
                        bus.avs_s1_read = 1'b0;
                        sb_pop();
                    end
                    if (led8[0] != v) break;
                    run++;
                end
                check("blink_run_len", run, 512);
            end
        end

        // Reset in the middle of a lit blink phase.
        rd_reg(5'h00, 16'h0001, 16'hFFFF, 1'b0, "pre_reset_on");
        found = 1'b0;
        for (int t = 0; t < 600 && !found; t++) begin
            @(negedge clk);
            if (led8[0]) found = 1'b1;
        end
        check("reset_lit_before", found, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_leds8", led8, 8'h00);
        check("reset_mid_leds4", led4, 4'h0);
        check("reset_mid_readdata", bus.avs_s1_readdata, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        rd_reg(5'h00, 16'h0000, 16'hFFFF, 1'b0, "post_reset_on");
        rd_reg(5'h03, 16'h0000, 16'hFFFF, 1'b0, "post_reset_blink_div");
`else
        // Fade: effective duty climbs 0 -> 4 over four PWM periods.
        do_reset();
        rst = 1'b0;
        wr_reg(5'h00, 16'h0001);
        wr_reg(5'h10, 16'd4);
        rd_reg(5'h04, 16'h0002, 16'h0002, 1'b0, "fade_busy");
        repeat (1100) @(negedge clk);
        rd_reg(5'h04, 16'h0000, 16'h0002, 1'b0, "fade_done");
        count_lit(1024, 0, cnt);
        check("fade_lit_cycles", cnt, 16);
`endif

        // Four-channel instance: DUTY slot 7 does not exist there.
        wr_reg(5'h17, 16'h00AB);
        wr_reg(5'h13, 16'h0042);
        wr_reg(5'h00, 16'h00FF);
        rd_reg(5'h17, 16'h00AB, 16'hFFFF, 1'b0, "ch8_duty7");
        rd_reg(5'h17, 16'h0000, 16'hFFFF, 1'b1, "ch4_addr17_ignored");
        rd_reg(5'h13, 16'h0042, 16'hFFFF, 1'b1, "ch4_duty3");
        rd_reg(5'h00, 16'h000F, 16'hFFFF, 1'b1, "ch4_on_trunc");

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
